// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (instr/data) req/gnt arbiter onto one downstream memory port
// Tracks outstanding transfers in an ID FIFO so responses return to the requester that issued them.
module mem_port_arbiter #(
    parameter int MaxOutstanding = 2,
    parameter bit DataPriority   = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        unexp_rsp_o
);

    localparam int PtrW = 2;
    localparam int CntW = 3;

    typedef enum logic [1:0] {
        LOCK_NONE  = 2'd0,
        LOCK_DATA  = 2'd1,
        LOCK_INSTR = 2'd2
    } lock_e;

    lock_e           lock_q, lock_d;
    logic            last_instr_q, last_instr_d;
    logic [3:0]      id_q, id_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            unexp_q, unexp_d;

    logic sel_instr;
    logic sel_req;
    logic can_issue;
    logic req;
    logic xfer;
    logic pop;
    logic head_instr;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // A stalled request keeps its owner; otherwise the round-robin pointer favours the port not served last.
    always_comb begin
        sel_instr = 1'b0;
        case (lock_q)
            LOCK_INSTR: sel_instr = 1'b1;
            LOCK_DATA:  sel_instr = 1'b0;
            default: begin
                if (instr_req_i && data_req_i) begin
                    sel_instr = DataPriority ? 1'b0 : ~last_instr_q;
                end else begin
                    sel_instr = instr_req_i;
                end
            end
        endcase
    end

    // Fullness uses the registered count, so a same-cycle response cannot free a slot early.
    assign sel_req    = sel_instr ? instr_req_i : data_req_i;
    assign can_issue  = cnt_q < CntW'(MaxOutstanding);
    assign req        = rst_ni & sel_req & can_issue;
    assign xfer       = req & mem_gnt_i;
    assign pop        = rst_ni & mem_rvalid_i & (cnt_q != '0);
    assign head_instr = id_q[rd_ptr_q];

    always_comb begin
        lock_d       = LOCK_NONE;
        last_instr_d = last_instr_q;
        id_d         = id_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q + CntW'(xfer) - CntW'(pop);
        unexp_d      = unexp_q | (mem_rvalid_i & (cnt_q == '0));

        if (req && !mem_gnt_i) begin
            lock_d = sel_instr ? LOCK_INSTR : LOCK_DATA;
        end
        if (xfer) begin
            last_instr_d   = sel_instr;
            id_d[wr_ptr_q] = sel_instr;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q       <= LOCK_NONE;
            last_instr_q <= 1'b1;
            id_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            unexp_q      <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            last_instr_q <= last_instr_d;
            id_q         <= id_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            unexp_q      <= unexp_d;
        end
    end

    // Downstream fields are forced to zero while reset is asserted.
    assign mem_req_o   = req;
    assign mem_we_o    = rst_ni & ~sel_instr & data_we_i;
    assign mem_be_o    = !rst_ni ? 4'h0 : (sel_instr ? 4'hF : data_be_i);
    assign mem_addr_o  = !rst_ni ? 32'h0 : (sel_instr ? instr_addr_i : data_addr_i);
    assign mem_wdata_o = (rst_ni && !sel_instr) ? data_wdata_i : 32'h0;

    assign instr_gnt_o = xfer & sel_instr;
    assign data_gnt_o  = xfer & ~sel_instr;

    assign instr_rvalid_o = pop & head_instr;
    assign data_rvalid_o  = pop & ~head_instr;
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0;
    assign data_err_o     = data_rvalid_o & mem_err_i;

    assign unexp_rsp_o = unexp_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter with a queue-based reference model
module tb_mem_port_arbiter;

    localparam int MO = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;
    logic        unexp_rsp_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.MaxOutstanding(MO), .DataPriority(1'b0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .unexp_rsp_o(unexp_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    // Reference model: a queue of outstanding owners (1 = instr), the last winner and any stalled owner.
    bit mq[$];
    bit last_instr_m = 1'b1;
    int pend_m = -1;
    bit unexp_m = 1'b0;
    bit own_i, ereq, exfer, hit, head;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            chk("m_rst_ctl", 32'({mem_req_o, mem_we_o, mem_be_o, instr_gnt_o, data_gnt_o,
                                  instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o,
                                  unexp_rsp_o}), 32'd0);
            chk("m_rst_addr", mem_addr_o, 32'd0);
            chk("m_rst_wdata", mem_wdata_o, 32'd0);
            chk("m_rst_irdata", instr_rdata_o, 32'd0);
            chk("m_rst_drdata", data_rdata_o, 32'd0);
            mq.delete();
            last_instr_m = 1'b1;
            pend_m = -1;
            unexp_m = 1'b0;
        end else begin
            if (pend_m >= 0)                     own_i = (pend_m == 1);
            else if (instr_req_i && data_req_i)  own_i = !last_instr_m;
            else                                 own_i = instr_req_i;
            ereq  = (own_i ? instr_req_i : data_req_i) && (mq.size() < MO);
            exfer = ereq && mem_gnt_i;
            chk("m_req", 32'(mem_req_o), 32'(ereq));
            chk("m_ignt", 32'(instr_gnt_o), 32'(exfer && own_i));
            chk("m_dgnt", 32'(data_gnt_o), 32'(exfer && !own_i));
            if (ereq) begin
                chk("m_addr", mem_addr_o, own_i ? instr_addr_i : data_addr_i);
                chk("m_we", 32'(mem_we_o), own_i ? 32'd0 : 32'(data_we_i));
                chk("m_be", 32'(mem_be_o), own_i ? 32'hF : 32'(data_be_i));
                chk("m_wdata", mem_wdata_o, own_i ? 32'd0 : data_wdata_i);
            end
            hit  = mem_rvalid_i && (mq.size() > 0);
            head = hit ? mq[0] : 1'b0;
            chk("m_irv", 32'(instr_rvalid_o), 32'(hit && head));
            chk("m_drv", 32'(data_rvalid_o), 32'(hit && !head));
            chk("m_irdata", instr_rdata_o, (hit && head) ? mem_rdata_i : 32'd0);
            chk("m_drdata", data_rdata_o, (hit && !head) ? mem_rdata_i : 32'd0);
            chk("m_ierr", 32'(instr_err_o), 32'(hit && head && mem_err_i));
            chk("m_derr", 32'(data_err_o), 32'(hit && !head && mem_err_i));
            chk("m_unexp", 32'(unexp_rsp_o), 32'(unexp_m));
            if (mem_rvalid_i && mq.size() == 0) unexp_m = 1'b1;
            if (hit) void'(mq.pop_front());
            if (exfer) begin
                mq.push_back(own_i);
                last_instr_m = own_i;
            end
            pend_m = (ereq && !mem_gnt_i) ? (own_i ? 1 : 0) : -1;
        end
    end

    initial begin
        rst_ni = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'h1000;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF;
        data_addr_i = 32'h2000; data_wdata_i = 32'h0;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;
        smp();
        chk("rst_req", 32'(mem_req_o), 32'd0);
        nxt(); nxt();

        // Both requesting: data first, then alternating
        rst_ni = 1'b1;
        smp(); chk("a0_dgnt", 32'(data_gnt_o), 32'd1); chk("a0_ignt", 32'(instr_gnt_o), 32'd0);
        chk("a0_addr", mem_addr_o, 32'h2000);
        nxt(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11;
        smp(); chk("a1_ignt", 32'(instr_gnt_o), 32'd1); chk("a1_drv", 32'(data_rvalid_o), 32'd1);
        chk("a1_drdata", data_rdata_o, 32'h11);
        nxt(); mem_rdata_i = 32'h22;
        smp(); chk("a2_dgnt", 32'(data_gnt_o), 32'd1); chk("a2_irv", 32'(instr_rvalid_o), 32'd1);
        chk("a2_irdata", instr_rdata_o, 32'h22);
        nxt(); instr_req_i = 1'b0; data_req_i = 1'b0; mem_rdata_i = 32'h33;
        smp(); chk("a3_drv", 32'(data_rvalid_o), 32'd1); chk("a3_req", 32'(mem_req_o), 32'd0);
        nxt(); mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_gnt_i = 1'b0;

        // Stalled instr request holds its fields against a competing data request
        instr_req_i = 1'b1; instr_addr_i = 32'h100;
        smp(); chk("b0_req", 32'(mem_req_o), 32'd1); chk("b0_ignt", 32'(instr_gnt_o), 32'd0);
        nxt(); data_req_i = 1'b1; data_addr_i = 32'h200;
        smp(); chk("b1_addr", mem_addr_o, 32'h100); chk("b1_dgnt", 32'(data_gnt_o), 32'd0);
        nxt();
        smp(); chk("b2_addr", mem_addr_o, 32'h100);
        nxt(); mem_gnt_i = 1'b1;
        smp(); chk("b3_ignt", 32'(instr_gnt_o), 32'd1); chk("b3_addr", mem_addr_o, 32'h100);
        nxt(); instr_req_i = 1'b0;
        smp(); chk("b4_dgnt", 32'(data_gnt_o), 32'd1); chk("b4_addr", mem_addr_o, 32'h200);
        nxt(); data_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hB1;
        smp(); chk("b5_irv", 32'(instr_rvalid_o), 32'd1);
        nxt(); mem_rdata_i = 32'hB2;
        smp(); chk("b6_drv", 32'(data_rvalid_o), 32'd1);
        nxt(); mem_rvalid_i = 1'b0;

        // Full FIFO blocks the third read until a response has been taken
        data_req_i = 1'b1; data_addr_i = 32'h400;
        smp(); chk("c0_dgnt", 32'(data_gnt_o), 32'd1);
        nxt();
        smp(); chk("c1_dgnt", 32'(data_gnt_o), 32'd1);
        nxt();
        smp(); chk("c2_req", 32'(mem_req_o), 32'd0); chk("c2_dgnt", 32'(data_gnt_o), 32'd0);
        nxt();
        smp(); chk("c3_req", 32'(mem_req_o), 32'd0);
        nxt(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hC1;
        smp(); chk("c4_req", 32'(mem_req_o), 32'd0); chk("c4_drv", 32'(data_rvalid_o), 32'd1);
        nxt(); mem_rvalid_i = 1'b0;
        smp(); chk("c5_dgnt", 32'(data_gnt_o), 32'd1);
        nxt(); data_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hC2;
        nxt(); mem_rdata_i = 32'hC3;
        nxt(); mem_rvalid_i = 1'b0;

        // Instr read then data write; responses routed in order
        instr_req_i = 1'b1; instr_addr_i = 32'h500;
        smp(); chk("d0_ignt", 32'(instr_gnt_o), 32'd1); chk("d0_we", 32'(mem_we_o), 32'd0);
        chk("d0_be", 32'(mem_be_o), 32'hF);
        nxt(); instr_req_i = 1'b0; data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3;
        data_addr_i = 32'h300; data_wdata_i = 32'hDEADBEEF;
        smp(); chk("d1_dgnt", 32'(data_gnt_o), 32'd1); chk("d1_we", 32'(mem_we_o), 32'd1);
        chk("d1_be", 32'(mem_be_o), 32'h3); chk("d1_wdata", mem_wdata_o, 32'hDEADBEEF);
        nxt(); data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'hF; data_wdata_i = 32'h0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA0000;
        smp(); chk("d2_irv", 32'(instr_rvalid_o), 32'd1); chk("d2_irdata", instr_rdata_o, 32'hAAAA0000);
        chk("d2_drv", 32'(data_rvalid_o), 32'd0); chk("d2_drdata", data_rdata_o, 32'h0);
        nxt(); mem_rdata_i = 32'h5555FFFF; mem_err_i = 1'b1;
        smp(); chk("d3_drv", 32'(data_rvalid_o), 32'd1); chk("d3_drdata", data_rdata_o, 32'h5555FFFF);
        chk("d3_derr", 32'(data_err_o), 32'd1); chk("d3_irv", 32'(instr_rvalid_o), 32'd0);
        chk("d3_irdata", instr_rdata_o, 32'h0);
        nxt(); mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = 32'h0;

        // Locked requester drops req: no transfer, lock released
        mem_gnt_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h600;
        smp(); chk("e0_req", 32'(mem_req_o), 32'd1);
        nxt(); instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h700;
        smp(); chk("e1_req", 32'(mem_req_o), 32'd0);
        nxt(); mem_gnt_i = 1'b1;
        smp(); chk("e2_dgnt", 32'(data_gnt_o), 32'd1); chk("e2_addr", mem_addr_o, 32'h700);
        nxt(); data_req_i = 1'b0; mem_rvalid_i = 1'b1;
        smp(); chk("e3_drv", 32'(data_rvalid_o), 32'd1);
        nxt(); mem_rvalid_i = 1'b0;

        // Response in the transfer's own cycle is unexpected; flag is sticky
        smp(); chk("f0_unexp", 32'(unexp_rsp_o), 32'd0);
        nxt(); data_req_i = 1'b1; data_addr_i = 32'h800; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hF1;
        smp(); chk("f1_dgnt", 32'(data_gnt_o), 32'd1); chk("f1_drv", 32'(data_rvalid_o), 32'd0);
        chk("f1_irv", 32'(instr_rvalid_o), 32'd0);
        nxt(); data_req_i = 1'b0; mem_rdata_i = 32'hF2;
        smp(); chk("f2_unexp", 32'(unexp_rsp_o), 32'd1); chk("f2_drv", 32'(data_rvalid_o), 32'd1);
        nxt(); mem_rvalid_i = 1'b0;
        nxt();
        smp(); chk("f3_unexp", 32'(unexp_rsp_o), 32'd1);

        // Reset with two outstanding discards them
        nxt(); data_req_i = 1'b1; data_addr_i = 32'h900;
        nxt();
        nxt(); rst_ni = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'hA00;
        smp(); chk("g0_req", 32'(mem_req_o), 32'd0); chk("g0_dgnt", 32'(data_gnt_o), 32'd0);
        chk("g0_unexp", 32'(unexp_rsp_o), 32'd0); chk("g0_addr", mem_addr_o, 32'h0);
        nxt(); data_req_i = 1'b0; rst_ni = 1'b1;
        smp(); chk("g1_req", 32'(mem_req_o), 32'd1); chk("g1_ignt", 32'(instr_gnt_o), 32'd1);
        chk("g1_unexp", 32'(unexp_rsp_o), 32'd0);
        nxt(); instr_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h61;
        smp(); chk("g2_irv", 32'(instr_rvalid_o), 32'd1);
        nxt(); mem_rdata_i = 32'h62;
        smp(); chk("g3_irv", 32'(instr_rvalid_o), 32'd0); chk("g3_drv", 32'(data_rvalid_o), 32'd0);
        nxt(); mem_rvalid_i = 1'b0;
        smp(); chk("g4_unexp", 32'(unexp_rsp_o), 32'd1);
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MaxOutstanding, default 2: maximum granted-but-unanswered transfers, legal range 1..4.
REQ-002 Parameter DataPriority, default 0: 1 = data always wins a conflict; 0 = round-robin.
REQ-003 Port clk_i  input  1: single clock, rising edge.
REQ-004 Port rst_ni  input  1: reset, asynchronous, active-low.
REQ-005 Ports instr_req_i in 1, instr_addr_i in 32: instruction requester (read-only; we=0, be=4'hF implied).
REQ-006 Ports instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32, instr_err_o out 1: instruction responses.
REQ-007 Ports data_req_i in 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32: data requester.
REQ-008 Ports data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32, data_err_o out 1: data responses.
REQ-009 Ports mem_req_o out 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out 32, mem_wdata_o out 32: shared downstream request, same req/gnt/rvalid protocol, feeding one AXI bridge.
REQ-010 Ports mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in 32, mem_err_i in 1: shared downstream response.
REQ-011 Port unexp_rsp_o  out  1: sticky flag, response received with nothing outstanding.

Function
REQ-012 Transfer = cycle with mem_req_o & mem_gnt_i; the requester that owns the request in that cycle receives gnt in the same cycle, combinationally; the other requester's gnt is 0.
REQ-013 mem_req_o asserts only when the selected requester's req is high and the outstanding count < MaxOutstanding.
REQ-014 Selection: one requester only -> that one; both -> DataPriority=1 picks data, else the requester not granted last (pointer reset = data first).
REQ-015 Lock: if mem_req_o is high and mem_gnt_i low, the selection is latched and held, with request fields unchanged, until the grant arrives; a competing request does not preempt.
REQ-016 Locked requester deasserting req (protocol violation): lock released next cycle, no transfer.
REQ-017 Round-robin pointer updates only on a transfer, to the granted requester.
REQ-018 Downstream fields are driven from the selected requester; instruction selection drives mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-019 ID FIFO, depth MaxOutstanding, pushes the granted requester ID on each transfer and pops on mem_rvalid_i.
REQ-020 mem_rvalid_i routes mem_rdata_i and mem_err_i to the head ID's rvalid/rdata/err in the same cycle (zero added latency); the other requester's rvalid is 0.
REQ-021 rdata/err outputs are valid only with their rvalid; when rvalid is 0 they drive 0.
REQ-022 A push and pop in the same cycle are both honoured; the count is unchanged and order is preserved; the pointers wrap modulo MaxOutstanding.
REQ-023 Full FIFO: mem_req_o held 0 and no gnt issued; a pop in the same cycle does not free the slot until the next cycle.
REQ-024 mem_rvalid_i with an empty FIFO: no rvalid to either requester, unexp_rsp_o set until reset.
REQ-025 Transfer to response latency is at least one cycle; a response in the transfer's own cycle counts as unexpected.

Reset
REQ-026 rst_ni low asynchronously clears the FIFO, count, lock, pointer (data first) and unexp_rsp_o.
REQ-027 During reset all outputs are 0.
REQ-028 Reset mid-operation discards outstanding IDs; later responses count as unexpected.

Verification
REQ-029 Both requesters assert in cycle 0, mem_gnt_i=1, DataPriority=0 -> data granted cycle 0, instr cycle 1, then alternating while both hold req.
REQ-030 Instr requests addr 0x100, mem_gnt_i low 3 cycles, data_req_i rises cycle 1 -> mem_addr_o stays 0x100 until the grant; data is granted the next cycle.
REQ-031 MaxOutstanding=2, three data reads granted back-to-back with no rvalid -> third mem_req_o held 0 until the first rvalid; released the following cycle.
REQ-032 Instr then data transfer, responses 0xAAAA0000 then 0x5555FFFF -> instr_rvalid_o with 0xAAAA0000, then data_rvalid_o with 0x5555FFFF; other rvalid 0.
REQ-033 mem_rvalid_i pulse with nothing outstanding -> no requester rvalid, unexp_rsp_o=1 held until rst_ni low.
REQ-034 rst_ni low with 2 outstanding, then released -> count 0, mem_req_o follows new requests immediately.
